// File: rtl/gpio_defaults_pkg.sv
// Shared types and helpers for the GPIO defaults loader.
// Holds the FSM state encoding and the serial bit-order helper.
package gpio_defaults_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_e;

    // Stream position to flat vector index: highest channel MSB goes first.
    function automatic int bit_index(input int cnt, input int total);
        return total - 1 - cnt;
    endfunction

endpackage

// File: rtl/gpio_defaults_serializer.sv
// Bit counter and output mux for the serial configuration chain.
// Walks the flattened shadow vector from its top bit down to bit 0.
module gpio_defaults_serializer
    import gpio_defaults_pkg::*;
#(
    parameter int TOTAL = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [TOTAL-1:0] bits_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam int CW = $clog2(TOTAL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        bit_o = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            if (i == bit_index(int'(cnt_q), TOTAL)) begin
                bit_o = bits_i[i];
            end
        end
    end

    assign last_o = (cnt_q == CW'(TOTAL - 1));

endmodule

// File: rtl/gpio_defaults_loader.sv
// Shadow configuration store for GPIO pads, shifted out serially
// on request and automatically once after reset.
module gpio_defaults_loader
    import gpio_defaults_pkg::*;
#(
    parameter int NUM_GPIO = 4,
    parameter int CFG_W    = 10,
    parameter logic [NUM_GPIO*CFG_W-1:0] DEFAULTS =
        {NUM_GPIO{CFG_W'(10'h009)}}
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rstn_i,
    input  logic                        load_req,
    input  logic                        ovr_we,
    input  logic [$clog2(NUM_GPIO)-1:0] ovr_sel,
    input  logic [CFG_W-1:0]            ovr_data,
    output logic [CFG_W-1:0]            rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        ovr_err,
    output logic                        serial_clock,
    output logic                        serial_load,
    output logic                        serial_data
);

    localparam int SEL_W = $clog2(NUM_GPIO);
    localparam int TOTAL = NUM_GPIO * CFG_W;

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   latch_q, latch_d;
    logic   ovr_err_q, ovr_err_d;

    logic [CFG_W-1:0] shadow_q [NUM_GPIO];
    logic [CFG_W-1:0] shadow_d [NUM_GPIO];
    logic [TOTAL-1:0] shadow_flat;

    logic sel_ok;
    logic wr_ok;
    logic ser_start;
    logic ser_step;
    logic ser_bit;
    logic ser_last;

    assign sel_ok = (int'(ovr_sel) < NUM_GPIO);
    assign wr_ok  = ovr_we && (state_q == IDLE) && sel_ok;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        latch_d   = 1'b0;
        ser_start = 1'b0;
        ser_step  = 1'b0;
        if (load_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (load_req || pending_q) begin
                    state_d   = SHIFT_LO;
                    pending_d = 1'b0;
                    ser_start = 1'b1;
                end
            end
            SHIFT_LO: state_d = SHIFT_HI;
            SHIFT_HI: begin
                ser_step = 1'b1;
                state_d  = ser_last ? LATCH : SHIFT_LO;
            end
            LATCH: begin
                latch_d = ~latch_q;
                if (latch_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests seen during the load chain straight into a new one.
                if (pending_q || load_req) begin
                    state_d   = SHIFT_LO;
                    pending_d = 1'b0;
                    ser_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovr_err_d = ovr_we && !wr_ok;
        for (int n = 0; n < NUM_GPIO; n++) begin
            shadow_d[n] = shadow_q[n];
            if (wr_ok && (ovr_sel == SEL_W'(n))) begin
                shadow_d[n] = ovr_data;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b1;
            latch_q   <= 1'b0;
            ovr_err_q <= 1'b0;
            for (int n = 0; n < NUM_GPIO; n++) begin
                shadow_q[n] <= DEFAULTS[n*CFG_W +: CFG_W];
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            latch_q   <= latch_d;
            ovr_err_q <= ovr_err_d;
            for (int n = 0; n < NUM_GPIO; n++) begin
                shadow_q[n] <= shadow_d[n];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NUM_GPIO; n++) begin
            shadow_flat[n*CFG_W +: CFG_W] = shadow_q[n];
            if (ovr_sel == SEL_W'(n)) begin
                rd_data = shadow_q[n];
            end
        end
    end

    gpio_defaults_serializer #(
        .TOTAL (TOTAL)
    ) u_ser (
        .clk    (wb_clk_i),
        .rst_n  (wb_rstn_i),
        .start  (ser_start),
        .step   (ser_step),
        .bits_i (shadow_flat),
        .bit_o  (ser_bit),
        .last_o (ser_last)
    );

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign ovr_err      = ovr_err_q;
    assign serial_clock = (state_q == SHIFT_HI);
    assign serial_load  = (state_q == LATCH);
    assign serial_data  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI))
                          ? ser_bit : 1'b0;

endmodule

// File: tb/tb_gpio_defaults_loader.sv
// Directed bench for the GPIO defaults loader.
// Main DUT has two channels; a three-channel copy covers bad selects.
module tb_gpio_defaults_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       load_req;
    logic       ovr_we;
    logic [0:0] ovr_sel;
    logic [9:0] ovr_data;
    logic [9:0] rd_data;
    logic       busy, done, ovr_err;
    logic       sclk, sload, sdata;

    logic       load_req3;
    logic       ovr_we3;
    logic [1:0] ovr_sel3;
    logic [9:0] ovr_data3;
    logic [9:0] rd_data3;
    logic       busy3, done3, err3;
    logic       sclk3, sload3, sdata3;

    gpio_defaults_loader #(
        .NUM_GPIO (2),
        .CFG_W    (10)
    ) u_dut (
        .wb_clk_i     (clk),
        .wb_rstn_i    (rstn),
        .load_req     (load_req),
        .ovr_we       (ovr_we),
        .ovr_sel      (ovr_sel),
        .ovr_data     (ovr_data),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .ovr_err      (ovr_err),
        .serial_clock (sclk),
        .serial_load  (sload),
        .serial_data  (sdata)
    );

    gpio_defaults_loader #(
        .NUM_GPIO (3),
        .CFG_W    (10)
    ) u_dut3 (
        .wb_clk_i     (clk),
        .wb_rstn_i    (rstn),
        .load_req     (load_req3),
        .ovr_we       (ovr_we3),
        .ovr_sel      (ovr_sel3),
        .ovr_data     (ovr_data3),
        .rd_data      (rd_data3),
        .busy         (busy3),
        .done         (done3),
        .ovr_err      (err3),
        .serial_clock (sclk3),
        .serial_load  (sload3),
        .serial_data  (sdata3)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_cnt = 0;
    int          ndone = 0;
    int          nload = 0;
    int          nbits = 0;
    int          done_cyc = 0;
    int          sd_bad = 0;
    logic [63:0] bits = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (sclk) begin
            bits  = {bits[62:0], sdata};
            nbits = nbits + 1;
        end
        if (sload) nload = nload + 1;
        if (done) begin
            ndone    = ndone + 1;
            done_cyc = edge_cnt;
        end
        if (sdata && !(busy && !sload && !done)) sd_bad = sd_bad + 1;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag,
                             input int base,
                             input int budget);
        int i = 0;
        while (ndone <= base && i < budget) begin
            step();
            i++;
        end
        chk(tag, 64'(ndone > base), 64'd1);
    endtask

    int t0, d0, l0, b0;

    initial begin
        rstn      = 1'b0;
        load_req  = 1'b0;
        ovr_we    = 1'b0;
        ovr_sel   = 1'b0;
        ovr_data  = '0;
        load_req3 = 1'b0;
        ovr_we3   = 1'b0;
        ovr_sel3  = '0;
        ovr_data3 = '0;
        repeat (3) step();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sload", sload, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_err", ovr_err, 0);
        chk("rst_rd0", rd_data, 10'h009);

        // auto-load after reset release
        d0 = ndone; l0 = nload; b0 = nbits;
        rstn = 1'b1;
        t0 = edge_cnt;
        wait_done("auto_done", d0, 100);
        chk("auto_lat", done_cyc - t0, 43);
        chk("auto_stream", bits[19:0], 20'h02409);
        chk("auto_nbits", nbits - b0, 20);
        chk("auto_nload", nload - l0, 2);
        chk("auto_idle", busy, 0);

        // write and load in the same idle cycle
        d0 = ndone;
        ovr_we = 1'b1; ovr_sel = 1'b1; ovr_data = 10'h3FF;
        load_req = 1'b1;
        t0 = edge_cnt;
        step();
        ovr_we = 1'b0; load_req = 1'b0;
        chk("wl_rd1", rd_data, 10'h3FF);
        chk("wl_err", ovr_err, 0);
        wait_done("wl_done", d0, 100);
        chk("wl_lat", done_cyc - t0, 43);
        chk("wl_stream", bits[19:0], 20'hFFC09);

        // write while busy is rejected
        d0 = ndone;
        load_req = 1'b1;
        t0 = edge_cnt;
        step();
        load_req = 1'b0;
        repeat (4) step();
        ovr_we = 1'b1; ovr_sel = 1'b0; ovr_data = 10'h155;
        step();
        ovr_we = 1'b0;
        chk("busy_err_pulse", ovr_err, 1);
        step();
        chk("busy_err_clear", ovr_err, 0);
        wait_done("busy_done", d0, 100);
        chk("busy_stream", bits[19:0], 20'hFFC09);
        chk("busy_rd0", rd_data, 10'h009);

        // two requests during a load coalesce into one extra load
        d0 = ndone; l0 = nload;
        load_req = 1'b1;
        t0 = edge_cnt;
        step();
        load_req = 1'b0;
        repeat (2) step();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (6) step();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        wait_done("pend_done1", d0, 100);
        chk("pend_lat1", done_cyc - t0, 43);
        wait_done("pend_done2", d0 + 1, 100);
        chk("pend_lat2", done_cyc - t0, 86);
        chk("pend_stream", bits[19:0], 20'hFFC09);
        repeat (60) step();
        chk("pend_ndone", ndone - d0, 2);
        chk("pend_nload", nload - l0, 4);
        chk("pend_idle", busy, 0);

        // reset in the middle of bit 7
        l0 = nload;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (14) step();
        chk("mid_busy_pre", busy, 1);
        rstn = 1'b0;
        step();
        chk("mid_busy", busy, 0);
        chk("mid_sclk", sclk, 0);
        chk("mid_sdata", sdata, 0);
        chk("mid_sload", sload, 0);
        chk("mid_done", done, 0);
        step();
        ovr_sel = 1'b1;
        #1;
        chk("mid_rd1", rd_data, 10'h009);
        chk("mid_nload", nload - l0, 0);
        d0 = ndone;
        rstn = 1'b1;
        t0 = edge_cnt;
        wait_done("mid_done2", d0, 100);
        chk("mid_lat", done_cyc - t0, 43);
        chk("mid_stream", bits[19:0], 20'h02409);

        // out-of-range select on a three-channel instance
        begin
            int i = 0;
            while (busy3 && i < 200) begin
                step();
                i++;
            end
        end
        chk("d3_idle", busy3, 0);
        ovr_we3 = 1'b1; ovr_sel3 = 2'd3; ovr_data3 = 10'h2AA;
        step();
        ovr_we3 = 1'b0;
        chk("d3_bad_err", err3, 1);
        ovr_sel3 = 2'd0; #1;
        chk("d3_rd0", rd_data3, 10'h009);
        ovr_sel3 = 2'd1; #1;
        chk("d3_rd1", rd_data3, 10'h009);
        ovr_sel3 = 2'd2; #1;
        chk("d3_rd2", rd_data3, 10'h009);
        ovr_we3 = 1'b1; ovr_data3 = 10'h155;
        step();
        ovr_we3 = 1'b0;
        chk("d3_ok_err", err3, 0);
        chk("d3_rd2_new", rd_data3, 10'h155);

        chk("sdata_idle", sd_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
